// File: rtl/dff_piso_pkg.sv
// Shared types and helpers for the flip-flop serial link transmitter.
package dff_piso_pkg;

   typedef enum logic {IDLE, SHIFT} piso_state_t;

   // Width of the bit counter for a WIDTH-bit word.
   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load shift register with enable-gated zero-fill shift toward the
// output end; exposes only the bit currently at the output end.
module piso_shreg
   import dff_piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_bit
);

   logic [WIDTH-1:0] r_q;

   // Clear on reset, load takes priority over shift, otherwise hold.
   always_ff @(posedge clk) begin
      if (!rst)
         r_q <= '0;
      else if (i_load)
         r_q <= i_data;
      else if (i_shift) begin
         if (MSB_FIRST != 0)
            r_q <= {r_q[WIDTH-2:0], 1'b0};
         else
            r_q <= {1'b0, r_q[WIDTH-1:1]};
      end
   end

   assign o_bit = (MSB_FIRST != 0) ? r_q[WIDTH-1] : r_q[0];

endmodule

// File: rtl/dff_piso_tx.sv
// Serial transmitter: accepts a word over valid/ready and shifts it out one
// bit per ser_en cycle with valid/last framing. Back-to-back words reload on
// the last bit so there is no idle gap between them.
module dff_piso_tx
   import dff_piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ser_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy
);

   localparam int            CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   piso_state_t   r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          w_load, w_shift, w_bit, w_at_last;

   assign w_at_last = (r_cnt == LAST);

   piso_shreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shreg (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (load_data),
      .o_bit   (w_bit)
   );

   // State and bit counter registers; reset abandons any word in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state, counter, handshake and shift-register controls.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      load_ready  = 1'b0;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      case (r_state)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) begin
               w_load      = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (ser_en) begin
               if (w_at_last) begin
                  // Last bit leaving: take the next word now if one is offered.
                  load_ready = 1'b1;
                  if (load_valid) begin
                     w_load    = 1'b1;
                     w_cnt_nxt = '0;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_shift   = 1'b1;
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // During reset nothing is accepted.
      if (!rst) begin
         load_ready = 1'b0;
         w_load     = 1'b0;
         w_shift    = 1'b0;
      end
   end

   assign busy      = (r_state == SHIFT);
   assign ser_valid = busy;
   assign ser_last  = busy && w_at_last;
   assign ser_out   = busy ? w_bit : 1'b0;

endmodule

// File: tb/tb_dff_piso_tx.sv
// Bench for dff_piso_tx: an MSB-first and an LSB-first instance share one
// stimulus stream and are checked against a word/position reference model.
module tb_dff_piso_tx;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         load_valid = 1'b0;
   logic         ser_en = 1'b0;
   logic [W-1:0] load_data = '0;

   logic m_ready, m_out, m_valid, m_last, m_busy;
   logic l_ready, l_out, l_valid, l_last, l_busy;

   dff_piso_tx #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(m_ready),
      .load_data(load_data), .ser_en(ser_en), .ser_out(m_out),
      .ser_valid(m_valid), .ser_last(m_last), .busy(m_busy)
   );

   dff_piso_tx #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(l_ready),
      .load_data(load_data), .ser_en(ser_en), .ser_out(l_out),
      .ser_valid(l_valid), .ser_last(l_last), .busy(l_busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: the word in flight and how many bit slots it has used.
   bit           active = 0;
   int           pos = 0;
   logic [W-1:0] word = '0;
   bit           accepted = 0;

   // Captured serial streams (valid cycles only) for directed tests.
   logic [31:0]  mcap = '0;
   logic [31:0]  lcap = '0;
   int           vcnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle, entered and left at a negedge.
   task automatic step(input logic r, input logic lv, input logic en, input logic [W-1:0] d);
      logic exp_ready, exp_last, exp_m, exp_l;
      exp_last = active && (pos == W - 1);
      exp_m    = active ? word[W-1-pos] : 1'b0;
      exp_l    = active ? word[pos]     : 1'b0;
      chk("valid_m", 32'(m_valid), 32'(active));
      chk("busy_m",  32'(m_busy),  32'(active));
      chk("last_m",  32'(m_last),  32'(exp_last));
      chk("out_m",   32'(m_out),   32'(exp_m));
      chk("valid_l", 32'(l_valid), 32'(active));
      chk("busy_l",  32'(l_busy),  32'(active));
      chk("last_l",  32'(l_last),  32'(exp_last));
      chk("out_l",   32'(l_out),   32'(exp_l));
      if (m_valid === 1'b1) begin
         mcap = {mcap[30:0], m_out};
         vcnt++;
      end
      if (l_valid === 1'b1) lcap = {lcap[30:0], l_out};

      rst = r; load_valid = lv; ser_en = en; load_data = d;
      #1;
      exp_ready = r && (!active || (pos == W - 1 && en));
      chk("ready_m", 32'(m_ready), 32'(exp_ready));
      chk("ready_l", 32'(l_ready), 32'(exp_ready));

      @(posedge clk);
      accepted = 0;
      if (!r) begin
         active = 0; pos = 0;
      end else if (lv && exp_ready) begin
         word = d; pos = 0; active = 1; accepted = 1;
      end else if (active && en) begin
         if (pos == W - 1) active = 0;
         else pos++;
      end
      @(negedge clk);
   endtask

   task automatic clr_cap();
      mcap = '0; lcap = '0; vcnt = 0;
   endtask

   initial begin
      logic         lv, en, r;
      logic [W-1:0] d;

      @(posedge clk);
      @(negedge clk);

      // Reset held with a word offered: nothing accepted, outputs quiet.
      repeat (3) step(1'b0, 1'b1, 1'b1, 8'h5A);
      step(1'b1, 1'b0, 1'b1, 8'h00);

      // Single word, MSB first.
      clr_cap();
      step(1'b1, 1'b1, 1'b1, 8'hA5);
      repeat (9) step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("single_stream", mcap, 32'h0000_00A5);
      chk("single_len", 32'(vcnt), 32'd8);

      // Back-to-back: second word taken on the last bit of the first.
      clr_cap();
      step(1'b1, 1'b1, 1'b1, 8'hA5);
      repeat (8) step(1'b1, 1'b1, 1'b1, 8'h3C);
      repeat (9) step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("b2b_stream", mcap, 32'h0000_A53C);
      chk("b2b_len", 32'(vcnt), 32'd16);

      // Stalling: ser_en alternates, each bit held for two cycles.
      clr_cap();
      step(1'b1, 1'b1, 1'b1, 8'hC3);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'(i % 2), 8'h00);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("stall_len", 32'(vcnt), 32'd16);

      // Reset mid-word, then a fresh word with no residue.
      step(1'b1, 1'b1, 1'b1, 8'hFF);
      repeat (3) step(1'b1, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      clr_cap();
      step(1'b1, 1'b1, 1'b1, 8'h0F);
      repeat (9) step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("rst_mid_stream", mcap, 32'h0000_000F);

      // LSB first: 8'h01 leaves as a 1 followed by seven 0s.
      clr_cap();
      step(1'b1, 1'b1, 1'b1, 8'h01);
      repeat (9) step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("lsb_stream", lcap, 32'h0000_0080);

      // Random traffic; an offered word is held until it is accepted.
      lv = 0; d = '0;
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 49) != 0);
         en = ($urandom_range(0, 3) != 0);
         if (!(lv && !accepted) || !rst) begin
            lv = ($urandom_range(0, 2) != 0);
            d  = W'($urandom);
         end
         step(r, lv, en, d);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
